// File: rtl/cpu_bus_ctrl_if.sv
// CPU-side bus bundle for cpu_bus_ctrl: CPU address/data bus, PRG ROM load port
// and the OAM write port produced by the sprite DMA engine.
interface cpu_bus_ctrl_if #(
  parameter int unsigned PRG_AW = 15
);
  logic [15:0]       cpu_addr;
  logic              cpu_rw;
  logic [7:0]        cpu_wdata;
  logic [7:0]        cpu_data;
  logic              cpu_rdy;
  logic              prg_we;
  logic [PRG_AW-1:0] prg_addr;
  logic [7:0]        prg_wdata;
  logic [7:0]        oam_addr;
  logic [7:0]        oam_data;
  logic              oam_we;
  logic              dma_active;

  modport master (
    output cpu_addr, cpu_rw, cpu_wdata, prg_we, prg_addr, prg_wdata,
    input  cpu_data, cpu_rdy, oam_addr, oam_data, oam_we, dma_active
  );

  modport slave (
    input  cpu_addr, cpu_rw, cpu_wdata, prg_we, prg_addr, prg_wdata,
    output cpu_data, cpu_rdy, oam_addr, oam_data, oam_we, dma_active
  );
endinterface

// File: rtl/cpu_bus_ctrl.sv
// CPU memory subsystem: mirrored work RAM, loadable PRG ROM, open-bus latch
// and the $4014 sprite DMA engine that halts the CPU through cpu_rdy.
module cpu_bus_ctrl #(
  parameter int unsigned PRG_AW = 15,
  parameter int unsigned RAM_AW = 11
) (
  input  logic          clk_ph1,
  input  logic          rst,
  cpu_bus_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_ALIGN2,
    S_READ,
    S_WRITE
  } state_t;

  logic [7:0] ram [2**RAM_AW];
  logic [7:0] rom [2**PRG_AW];

  state_t     state_q, state_d;
  logic [7:0] page_q, page_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] byte_q, byte_d;
  logic [7:0] ob_q, ob_d;
  logic       odd_q, odd_d;
  logic       par_q;
  logic       rdy_q;
  logic       act_q;
  logic       oam_we_c;

  logic [15:0] dec_addr;
  logic        is_ram, is_rom, dec_hit;
  logic [7:0]  ram_rd, rom_rd, dec_byte;
  logic        cpu_wr, trigger;

  // Single shared decoder: the DMA engine owns it in READ, the CPU otherwise
  // (the CPU only ever sees ob while DMA is running, so nothing is lost).
  always_comb begin
    dec_addr = (state_q == S_READ) ? {page_q, idx_q} : bus.cpu_addr;
    is_ram   = (dec_addr[15:13] == 3'b000);
    is_rom   = dec_addr[15];
    ram_rd   = ram[dec_addr[RAM_AW-1:0]];
    rom_rd   = rom[dec_addr[PRG_AW-1:0]];
    dec_hit  = is_ram | is_rom;
    dec_byte = is_ram ? ram_rd : (is_rom ? rom_rd : ob_q);
  end

  assign cpu_wr  = (state_q == S_IDLE) && !bus.cpu_rw;
  assign trigger = cpu_wr && (bus.cpu_addr == 16'h4014);

  // DMA next-state, datapath next values and open-bus update.
  always_comb begin
    state_d  = state_q;
    page_d   = page_q;
    idx_d    = idx_q;
    byte_d   = byte_q;
    odd_d    = odd_q;
    ob_d     = ob_q;
    oam_we_c = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!bus.cpu_rw) begin
          ob_d = bus.cpu_wdata;
        end else if (dec_hit) begin
          ob_d = dec_byte;
        end
        if (trigger) begin
          state_d = S_ALIGN;
          page_d  = bus.cpu_wdata;
          idx_d   = '0;
          odd_d   = par_q;
        end
      end
      S_ALIGN:  state_d = odd_q ? S_ALIGN2 : S_READ;
      S_ALIGN2: state_d = S_READ;
      S_READ: begin
        byte_d  = dec_byte;
        ob_d    = dec_byte;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        oam_we_c = 1'b1;
        idx_d    = idx_q + 8'd1;
        state_d  = (idx_q == 8'hFF) ? S_IDLE : S_READ;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control/datapath registers; cpu_rdy and dma_active are registered from next state.
  always_ff @(posedge clk_ph1 or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      page_q  <= '0;
      idx_q   <= '0;
      byte_q  <= '0;
      ob_q    <= '0;
      odd_q   <= 1'b0;
      par_q   <= 1'b0;
      rdy_q   <= 1'b1;
      act_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      idx_q   <= idx_d;
      byte_q  <= byte_d;
      ob_q    <= ob_d;
      odd_q   <= odd_d;
      par_q   <= ~par_q;
      rdy_q   <= (state_d == S_IDLE);
      act_q   <= (state_d != S_IDLE);
    end
  end

  // Work RAM write port; CPU writes only while not halted.
  always_ff @(posedge clk_ph1) begin
    if (cpu_wr && (bus.cpu_addr[15:13] == 3'b000)) begin
      ram[bus.cpu_addr[RAM_AW-1:0]] <= bus.cpu_wdata;
    end
  end

  // PRG ROM load port; reads are asynchronous so a same-cycle read sees the old byte.
  always_ff @(posedge clk_ph1) begin
    if (bus.prg_we) begin
      rom[bus.prg_addr] <= bus.prg_wdata;
    end
  end

  assign bus.cpu_data   = (state_q == S_IDLE) ? dec_byte : ob_q;
  assign bus.cpu_rdy    = rdy_q;
  assign bus.dma_active = act_q;
  assign bus.oam_we     = oam_we_c;
  assign bus.oam_addr   = idx_q;
  assign bus.oam_data   = byte_q;

endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// Directed bench for cpu_bus_ctrl: decode/mirroring, open bus, ROM loading,
// sprite DMA timing on both parities and reset during DMA.
module tb_cpu_bus_ctrl;

  logic clk;
  logic rst_n;

  cpu_bus_ctrl_if #(.PRG_AW(15)) bus ();
  cpu_bus_ctrl_if #(.PRG_AW(14)) bus14 ();

  cpu_bus_ctrl #(.PRG_AW(15), .RAM_AW(11)) dut (
    .clk_ph1 (clk),
    .rst     (rst_n),
    .bus     (bus.slave)
  );

  cpu_bus_ctrl #(.PRG_AW(14), .RAM_AW(11)) dut14 (
    .clk_ph1 (clk),
    .rst     (rst_n),
    .bus     (bus14.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Cycle index since reset release; its LSB is the expected parity.
  int unsigned cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // DMA observer: counts halted cycles and OAM strobes, checks each byte.
  logic [7:0] dma_exp [256];
  logic [7:0] next_addr = 8'h00;
  int we_total  = 0;
  int low_total = 0;
  int bad_total = 0;
  always @(negedge clk) begin
    if (!bus.cpu_rdy) low_total++;
    if (bus.oam_we === 1'b1) begin
      if (bus.oam_addr !== next_addr || bus.oam_data !== dma_exp[next_addr]) bad_total++;
      we_total++;
      next_addr = next_addr + 8'd1;
    end
    if (bus.cpu_rdy === 1'b1) next_addr = 8'h00;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    bus.cpu_addr  = a;
    bus.cpu_rw    = 1'b0;
    bus.cpu_wdata = d;
    tick();
    bus.cpu_rw    = 1'b1;
    bus.cpu_addr  = 16'h4000;
  endtask

  task automatic cpu_read(input string tag, input logic [15:0] a, input logic [7:0] exp);
    bus.cpu_addr = a;
    bus.cpu_rw   = 1'b1;
    #1;
    chk(tag, bus.cpu_data, exp);
    tick();
  endtask

  task automatic prg_load(input logic [14:0] a, input logic [7:0] d);
    bus.prg_we    = 1'b1;
    bus.prg_addr  = a;
    bus.prg_wdata = d;
    tick();
    bus.prg_we    = 1'b0;
  endtask

  task automatic align_par(input logic p);
    if (cyc[0] != p) tick();
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 2000 && bus.cpu_rdy !== 1'b1; i++) tick();
    chk(tag, bus.cpu_rdy, 1'b1);
  endtask

  task automatic run_dma(input string tag, input logic p, input int exp_low);
    int we0, low0, bad0;
    align_par(p);
    we0  = we_total;
    low0 = low_total;
    bad0 = bad_total;
    cpu_write(16'h4014, 8'h02);
    bus.cpu_addr = 16'h4014;
    chk({tag, "_active"}, bus.dma_active, 1'b1);
    wait_idle({tag, "_done"});
    chk({tag, "_rdy_low"}, low_total - low0, exp_low);
    chk({tag, "_we_cnt"}, we_total - we0, 256);
    chk({tag, "_bytes"}, bad_total - bad0, 0);
  endtask

  initial begin
    int we0;
    bus.cpu_addr    = 16'h4000;
    bus.cpu_rw      = 1'b1;
    bus.cpu_wdata   = 8'h00;
    bus.prg_we      = 1'b0;
    bus.prg_addr    = '0;
    bus.prg_wdata   = 8'h00;
    bus14.cpu_addr  = 16'h4000;
    bus14.cpu_rw    = 1'b1;
    bus14.cpu_wdata = 8'h00;
    bus14.prg_we    = 1'b0;
    bus14.prg_addr  = '0;
    bus14.prg_wdata = 8'h00;
    for (int i = 0; i < 256; i++) dma_exp[i] = 8'(i) ^ 8'hFF;
    rst_n = 1'b0;

    // 1. reset state
    tick(); tick();
    #1;
    chk("rst_data", bus.cpu_data, 8'h00);
    chk("rst_rdy", bus.cpu_rdy, 1'b1);
    chk("rst_oam_we", bus.oam_we, 1'b0);
    chk("rst_active", bus.dma_active, 1'b0);
    chk("rst_oam_addr", bus.oam_addr, 8'h00);
    tick();
    rst_n = 1'b1;
    tick();

    // ROM content used by later steps
    prg_load(15'h0000, 8'h3C);
    prg_load(15'h0001, 8'h55);

    // 2. RAM mirroring and dropped ROM write
    cpu_write(16'h0105, 8'hA5);
    cpu_read("ram_0105", 16'h0105, 8'hA5);
    cpu_read("ram_0905", 16'h0905, 8'hA5);
    cpu_read("ram_1905", 16'h1905, 8'hA5);
    cpu_write(16'h8000, 8'h77);
    cpu_read("rom_wr_drop", 16'h8000, 8'h3C);

    // 3. reset vector load, same-cycle load returns old byte, 16 KB mirror
    prg_load(15'h7FFC, 8'h00);
    prg_load(15'h7FFD, 8'h80);
    cpu_read("vec_fffc", 16'hFFFC, 8'h00);
    cpu_read("vec_fffd", 16'hFFFD, 8'h80);
    bus.prg_we    = 1'b1;
    bus.prg_addr  = 15'h0001;
    bus.prg_wdata = 8'hAA;
    cpu_read("prg_same_cyc_old", 16'h8001, 8'h55);
    bus.prg_we    = 1'b0;
    cpu_read("prg_new", 16'h8001, 8'hAA);
    bus14.prg_we    = 1'b1;
    bus14.prg_addr  = 14'h3FFC;
    bus14.prg_wdata = 8'h5A;
    tick();
    bus14.prg_we    = 1'b0;
    bus14.cpu_addr  = 16'hBFFC;
    #1;
    chk("rom14_bffc", bus14.cpu_data, 8'h5A);
    bus14.cpu_addr  = 16'hFFFC;
    #1;
    chk("rom14_fffc", bus14.cpu_data, 8'h5A);

    // 4. open bus
    cpu_write(16'h0000, 8'h12);
    cpu_read("ob_after_wr_4000", 16'h4000, 8'h12);
    cpu_read("ob_after_wr_5000", 16'h5000, 8'h12);
    cpu_read("rom_0000", 16'h8000, 8'h3C);
    cpu_read("ob_after_rom", 16'h4000, 8'h3C);
    cpu_read("ram_0000", 16'h0000, 8'h12);

    // 5. DMA from page $02, even then odd trigger parity
    for (int i = 0; i < 256; i++) cpu_write(16'h0200 + 16'(i), 8'(i) ^ 8'hFF);
    cpu_read("ram_02ff", 16'h02FF, 8'h00);
    cpu_read("ram_0210", 16'h0210, 8'hEF);
    run_dma("dma_even", 1'b0, 513);
    cpu_read("ob_after_dma", 16'h4000, 8'h00);
    run_dma("dma_odd", 1'b1, 514);

    // 6. reset in the middle of a transfer
    align_par(1'b0);
    we0 = we_total;
    cpu_write(16'h4014, 8'h02);
    bus.cpu_addr = 16'h4014;
    for (int i = 0; i < 1000 && (we_total - we0) < 100; i++) tick();
    chk("abort_we_cnt", we_total - we0, 100);
    rst_n = 1'b0;
    #1;
    chk("abort_oam_we", bus.oam_we, 1'b0);
    chk("abort_rdy", bus.cpu_rdy, 1'b1);
    chk("abort_active", bus.dma_active, 1'b0);
    tick(); tick(); tick();
    chk("abort_no_more_we", we_total - we0, 100);
    rst_n = 1'b1;
    tick();
    run_dma("dma_after_rst", 1'b0, 513);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
